// File: rtl/masked_unmask_pkg.sv
// Shared types and elaboration-time helpers for the sequential unmasking controller.
package masked_unmask_pkg;

   localparam logic [1:0] StIdleEnc = 2'd0;
   localparam logic [1:0] StBusyEnc = 2'd1;
   localparam logic [1:0] StDoneEnc = 2'd2;

   typedef enum logic [1:0] {
      StIdle = StIdleEnc,
      StBusy = StBusyEnc,
      StDone = StDoneEnc
   } state_e;

   // Number of reduction cycles needed to unmask a full word.
   function automatic int unsigned n_cycles(input int unsigned w, input int unsigned c);
      return w / c;
   endfunction

   // Chunk counter width; at least one bit even when a single cycle suffices.
   function automatic int unsigned cnt_width(input int unsigned w, input int unsigned c);
      int unsigned n;
      n = w / c;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bin_redXOR.sv
// XOR-reduction gate over W share bits. Kept as its own module so synthesis treats
// each instance as a boundary and cannot merge share bits anywhere else.
module bin_redXOR #(
   parameter int unsigned W = 2
) (
   input  logic [W-1:0] x_i,
   output logic         y_o
);

   assign y_o = ^x_i;

endmodule

// File: rtl/unmask_chunk.sv
// Recombines C bits of a bit-major d-share sharing. This is the only place where
// shares of the same bit meet.
module unmask_chunk #(
   parameter int unsigned d = 2,
   parameter int unsigned C = 32
) (
   input  logic [d*C-1:0] sh_i,
   output logic [C-1:0]   bits_o
);

   for (genvar i = 0; i < C; i++) begin : g_bit
      bin_redXOR #(
         .W (d)
      ) u_red (
         .x_i (sh_i[d*i +: d]),
         .y_o (bits_o[i])
      );
   end

endmodule

// File: rtl/masked_unmask_seq.sv
// Sequential share-recombination controller: accepts one d-share sharing of a W-bit
// word and unmasks it C bits per cycle, then presents the result behind an output gate.
module masked_unmask_seq
   import masked_unmask_pkg::*;
#(
   parameter int unsigned d = 2,
   parameter int unsigned W = 128,
   parameter int unsigned C = 32
) (
   input  logic           clk,
   input  logic           syn_rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [d*W-1:0] in_sh,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic           busy
);

   localparam int unsigned N  = n_cycles(W, C);
   localparam int unsigned CW = cnt_width(W, C);
   localparam logic [CW-1:0] CntLast = CW'(N - 1);

   if (W % C != 0) begin : g_bad_chunk
      $error("masked_unmask_seq: W must be a multiple of C");
   end
   if (d < 2) begin : g_bad_shares
      $error("masked_unmask_seq: d must be at least 2");
   end

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [d*W-1:0]  sh_q;
   logic [W-1:0]    result_q;
   logic [C-1:0]    chunk_bits;

   // Lowest chunk of the share register is always the one being reduced.
   unmask_chunk #(
      .d (d),
      .C (C)
   ) u_chunk (
      .sh_i   (sh_q[d*C-1:0]),
      .bits_o (chunk_bits)
   );

   // FSM plus share/result datapath; reset wins over every other event.
   always_ff @(posedge clk) begin
      if (syn_rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sh_q     <= '0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  sh_q     <= in_sh;
                  result_q <= '0;
                  cnt_q    <= '0;
                  state_q  <= StBusy;
               end
            end
            StBusy: begin
               result_q[int'(cnt_q)*C +: C] <= chunk_bits;
               // Zero-fill shift leaves no share residue once the last chunk is consumed.
               sh_q <= sh_q >> (d*C);
               if (cnt_q == CntLast) begin
                  cnt_q   <= '0;
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            StDone: begin
               if (out_ready) begin
                  result_q <= '0;
                  state_q  <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Handshake flags decode straight from the state flop; no in_* to out_* path.
   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q == StBusy) || (state_q == StDone);
   assign out_data  = result_q & {W{out_valid}};

endmodule

// File: tb/tb_masked_unmask_seq.sv
// Directed bench for masked_unmask_seq across three parameter sets.
module tb_masked_unmask_seq;

   logic clk = 1'b0;
   logic syn_rst;

   // d=2, W=8, C=4 (N=2)
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [15:0] a_in_sh;
   logic [7:0]  a_out_data;
   // d=3, W=8, C=8 (N=1)
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [23:0] b_in_sh;
   logic [7:0]  b_out_data;
   // defaults d=2, W=128, C=32 (N=4)
   logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
   logic [255:0] c_in_sh;
   logic [127:0] c_out_data;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   masked_unmask_seq #(.d(2), .W(8), .C(4)) u_a (
      .clk (clk), .syn_rst (syn_rst), .in_valid (a_in_valid), .in_ready (a_in_ready),
      .in_sh (a_in_sh), .out_valid (a_out_valid), .out_ready (a_out_ready),
      .out_data (a_out_data), .busy (a_busy)
   );

   masked_unmask_seq #(.d(3), .W(8), .C(8)) u_b (
      .clk (clk), .syn_rst (syn_rst), .in_valid (b_in_valid), .in_ready (b_in_ready),
      .in_sh (b_in_sh), .out_valid (b_out_valid), .out_ready (b_out_ready),
      .out_data (b_out_data), .busy (b_busy)
   );

   masked_unmask_seq u_c (
      .clk (clk), .syn_rst (syn_rst), .in_valid (c_in_valid), .in_ready (c_in_ready),
      .in_sh (c_in_sh), .out_valid (c_out_valid), .out_ready (c_out_ready),
      .out_data (c_out_data), .busy (c_busy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit-major interleave of two shares.
   function automatic logic [255:0] il2(input logic [127:0] s0, input logic [127:0] s1);
      logic [255:0] r;
      for (int i = 0; i < 128; i++) begin
         r[2*i]   = s0[i];
         r[2*i+1] = s1[i];
      end
      return r;
   endfunction

   function automatic logic [23:0] il3(input logic [7:0] s0, input logic [7:0] s1,
                                       input logic [7:0] s2);
      logic [23:0] r;
      for (int i = 0; i < 8; i++) begin
         r[3*i]   = s0[i];
         r[3*i+1] = s1[i];
         r[3*i+2] = s2[i];
      end
      return r;
   endfunction

   initial begin
      logic [255:0] tmp;
      logic [127:0] s0, s1;
      int hs_cyc, prev_hs;

      syn_rst = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_sh = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_sh = '0;
      c_in_valid = 1'b0; c_out_ready = 1'b1; c_in_sh = '0;
      #2;
      tick();
      syn_rst = 1'b0;

      // Reset state
      check("rst_in_ready", a_in_ready, 1);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_data", a_out_data, 0);
      check("rst_busy", a_busy, 0);
      check("rst_c_in_ready", c_in_ready, 1);

      // A: 0x3C ^ 0x99 = 0xA5, out_ready high
      tmp = il2(128'h3C, 128'h99);
      a_in_sh = tmp[15:0];
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      check("a_busy1_in_ready", a_in_ready, 0);
      check("a_busy1_busy", a_busy, 1);
      check("a_busy1_out_valid", a_out_valid, 0);
      check("a_busy1_out_data", a_out_data, 0);
      tick();
      check("a_busy2_in_ready", a_in_ready, 0);
      check("a_busy2_out_valid", a_out_valid, 0);
      tick();
      check("a_done_out_valid", a_out_valid, 1);
      check("a_done_out_data", a_out_data, 8'hA5);
      check("a_done_in_ready", a_in_ready, 0);
      tick();
      check("a_idle_in_ready", a_in_ready, 1);
      check("a_idle_out_valid", a_out_valid, 0);
      check("a_idle_out_data", a_out_data, 0);
      check("a_idle_busy", a_busy, 0);

      // A: stall in DONE, new sharing offered but must be ignored
      a_out_ready = 1'b0;
      a_in_valid = 1'b1;
      tick();
      tmp = il2(128'h00, 128'hFF);
      a_in_sh = tmp[15:0];
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check("a_stall_out_valid", a_out_valid, 1);
         check("a_stall_out_data", a_out_data, 8'hA5);
         check("a_stall_in_ready", a_in_ready, 0);
         tick();
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      tick();
      check("a_release_out_valid", a_out_valid, 0);
      check("a_release_in_ready", a_in_ready, 1);

      // B: N=1, 0xFF ^ 0x0F ^ 0x55 = 0xA5
      b_in_sh = il3(8'hFF, 8'h0F, 8'h55);
      b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      check("b_busy_busy", b_busy, 1);
      check("b_busy_out_valid", b_out_valid, 0);
      check("b_busy_in_ready", b_in_ready, 0);
      tick();
      check("b_done_out_valid", b_out_valid, 1);
      check("b_done_out_data", b_out_data, 8'hA5);
      check("b_done_sh_zero", u_b.sh_q, 0);
      tick();
      check("b_idle_in_ready", b_in_ready, 1);

      // A: reset during the second BUSY cycle, then a clean run of 0x5A ^ 0x66 = 0x3C
      tmp = il2(128'h3C, 128'h99);
      a_in_sh = tmp[15:0];
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      tick();
      syn_rst = 1'b1;
      tick();
      syn_rst = 1'b0;
      check("a_abort_in_ready", a_in_ready, 1);
      check("a_abort_out_valid", a_out_valid, 0);
      check("a_abort_out_data", a_out_data, 0);
      check("a_abort_busy", a_busy, 0);
      tick();
      check("a_abort_hold_valid", a_out_valid, 0);
      tmp = il2(128'h5A, 128'h66);
      a_in_sh = tmp[15:0];
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      tick();
      tick();
      check("a_post_out_valid", a_out_valid, 1);
      check("a_post_out_data", a_out_data, 8'h3C);
      tick();

      // C: back-to-back with in_valid held high
      c_in_valid = 1'b1;
      prev_hs = 0;
      for (int k = 0; k < 4; k++) begin
         s0 = {$urandom, $urandom, $urandom, $urandom};
         s1 = {$urandom, $urandom, $urandom, $urandom};
         c_in_sh = il2(s0, s1);
         check("c_accept_ready", c_in_ready, 1);
         tick();
         hs_cyc = cyc;
         if (k > 0) check("c_spacing", 128'(hs_cyc - prev_hs), 6);
         prev_hs = hs_cyc;
         for (int j = 0; j < 3; j++) begin
            check("c_busy_out_valid", c_out_valid, 0);
            check("c_busy_out_data", c_out_data, 0);
            tick();
         end
         check("c_busy_last_data", c_out_data, 0);
         tick();
         check("c_done_out_valid", c_out_valid, 1);
         check("c_done_out_data", c_out_data, s0 ^ s1);
         tick();
         check("c_idle_out_data", c_out_data, 0);
      end
      c_in_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
